// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the ALU operation issuer: sizes, ALU op codes,
// FSM state encodings, instruction word layout and op-code legality.
package alu_op_issuer_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned IDX_W  = $clog2(NREGS);
  localparam int unsigned CODE_W = 5;

  // Op class lives in alu_code[4:3]
  localparam logic [1:0] ALU_CLASS_ARITH = 2'b00;
  localparam logic [1:0] ALU_CLASS_LOGIC = 2'b01;
  localparam logic [1:0] ALU_CLASS_SHIFT = 2'b10;
  localparam logic [1:0] ALU_CLASS_CMP   = 2'b11;

  localparam logic [CODE_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [CODE_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [CODE_W-1:0] ALU_ADC = 5'b00010;
  localparam logic [CODE_W-1:0] ALU_SBC = 5'b00011;
  localparam logic [CODE_W-1:0] ALU_INC = 5'b00100;
  localparam logic [CODE_W-1:0] ALU_DEC = 5'b00101;
  localparam logic [CODE_W-1:0] ALU_NEG = 5'b00110;
  localparam logic [CODE_W-1:0] ALU_ABS = 5'b00111;
  localparam logic [CODE_W-1:0] ALU_AND = 5'b01000;
  localparam logic [CODE_W-1:0] ALU_OR  = 5'b01001;
  localparam logic [CODE_W-1:0] ALU_XOR = 5'b01010;
  localparam logic [CODE_W-1:0] ALU_NOT = 5'b01100;
  localparam logic [CODE_W-1:0] ALU_SHL = 5'b10000;
  localparam logic [CODE_W-1:0] ALU_SHR = 5'b10001;
  localparam logic [CODE_W-1:0] ALU_SAR = 5'b10010;
  localparam logic [CODE_W-1:0] ALU_ROL = 5'b10011;
  localparam logic [CODE_W-1:0] ALU_EQ  = 5'b11000;
  localparam logic [CODE_W-1:0] ALU_NE  = 5'b11001;
  localparam logic [CODE_W-1:0] ALU_LT  = 5'b11010;
  localparam logic [CODE_W-1:0] ALU_LTU = 5'b11011;
  localparam logic [CODE_W-1:0] ALU_GE  = 5'b11100;
  localparam logic [CODE_W-1:0] ALU_GEU = 5'b11101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_WB      = 2'd3;

  // Instruction word: [15:11] code, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] reserved
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  rs1;
    logic [IDX_W-1:0]  rs2;
    logic [1:0]        rsvd;
  } instr_t;

  function automatic logic [1:0] code_class(input logic [CODE_W-1:0] code);
    return code[4:3];
  endfunction

  function automatic logic is_legal_code(input logic [CODE_W-1:0] code);
    logic legal;
    case (code)
      ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBC, ALU_INC, ALU_DEC, ALU_NEG, ALU_ABS,
      ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
      ALU_SHL, ALU_SHR, ALU_SAR, ALU_ROL,
      ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_op_issuer_regfile.sv
// NREGS x WIDTH register file, two asynchronous read ports and two write
// ports; write port A (writeback) wins over port B (direct load) when both
// target the same index in the same cycle.
//   clk, rst_n          clock, async active-low reset (clears all entries)
//   ra1/rd1, ra2/rd2    read ports
//   wa_en/addr/data     write port A (high priority)
//   wb_en/addr/data     write port B (low priority)
module alu_op_issuer_regfile
  import alu_op_issuer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] ra1,
  input  logic [IDX_W-1:0] ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             wa_en,
  input  logic [IDX_W-1:0] wa_addr,
  input  logic [WIDTH-1:0] wa_data,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_addr,
  input  logic [WIDTH-1:0] wb_data
);

  logic [WIDTH-1:0] regs_q [NREGS];

  // Per-entry write with port A priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wa_en && (wa_addr == IDX_W'(i))) begin
          regs_q[i] <= wa_data;
        end else if (wb_en && (wb_addr == IDX_W'(i))) begin
          regs_q[i] <= wb_data;
        end
      end
    end
  end

  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];

endmodule

// File: rtl/alu_op_issuer.sv
// Command-side initiator for the 16-bit ALU. Accepts one instruction word at
// a time, reads operands from the internal register file, drives the ALU,
// captures its result and writes it back, then pulses res_valid.
//   in_valid/in_ready/in_instr   instruction port (ready only in IDLE)
//   ld_valid/ld_addr/ld_data     direct register load, accepted in any state
//   alu_a/alu_b/alu_code         registered ALU operands, change only in ISSUE
//   alu_c/alu_ovf                combinational ALU result
//   res_valid/data/rd/ovf/err    completion report, res_valid is one cycle
//   ovf_sticky/ovf_clr           accumulated overflow, set beats clear
module alu_op_issuer
  import alu_op_issuer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_instr,
  input  logic              ld_valid,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CODE_W-1:0] alu_code,
  input  logic [WIDTH-1:0]  alu_c,
  input  logic              alu_ovf,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_data,
  output logic [IDX_W-1:0]  res_rd,
  output logic              res_ovf,
  output logic              res_err,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [IDX_W-1:0]  rd_q, rd_d;
  logic [IDX_W-1:0]  rs1_q, rs1_d;
  logic [IDX_W-1:0]  rs2_q, rs2_d;

  logic              in_ready_d;
  logic [WIDTH-1:0]  alu_a_d, alu_b_d;
  logic [CODE_W-1:0] alu_code_d;
  logic              res_valid_d;
  logic [WIDTH-1:0]  res_data_d;
  logic [IDX_W-1:0]  res_rd_d;
  logic              res_ovf_d;
  logic              res_err_d;
  logic              ovf_sticky_d;

  logic [WIDTH-1:0]  rf_rd1, rf_rd2;
  logic              wb_en;
  instr_t            in_fields;
  logic              unused_rsvd;

  assign in_fields   = instr_t'(in_instr);
  assign unused_rsvd = ^in_fields.rsvd;

  // Writeback is suppressed for ops that completed with an illegal code
  assign wb_en = (state_q == ST_WB) && !res_err;

  alu_op_issuer_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra1     (rs1_q),
    .ra2     (rs2_q),
    .rd1     (rf_rd1),
    .rd2     (rf_rd2),
    .wa_en   (wb_en),
    .wa_addr (res_rd),
    .wa_data (res_data),
    .wb_en   (ld_valid),
    .wb_addr (ld_addr),
    .wb_data (ld_data)
  );

  // State and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      in_ready   <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_code   <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_rd     <= '0;
      res_ovf    <= 1'b0;
      res_err    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      in_ready   <= in_ready_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_code   <= alu_code_d;
      res_valid  <= res_valid_d;
      res_data   <= res_data_d;
      res_rd     <= res_rd_d;
      res_ovf    <= res_ovf_d;
      res_err    <= res_err_d;
      ovf_sticky <= ovf_sticky_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_code_d   = alu_code;
    res_valid_d  = 1'b0;
    res_data_d   = res_data;
    res_rd_d     = res_rd;
    res_ovf_d    = res_ovf;
    res_err_d    = res_err;
    ovf_sticky_d = ovf_sticky && !ovf_clr;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          code_d = in_fields.code;
          rd_d   = in_fields.rd;
          rs1_d  = in_fields.rs1;
          rs2_d  = in_fields.rs2;
          if (is_legal_code(in_fields.code)) begin
            state_d = ST_ISSUE;
          end else begin
            // Illegal ops skip the ALU and report straight from WB
            state_d     = ST_WB;
            res_valid_d = 1'b1;
            res_rd_d    = in_fields.rd;
            res_ovf_d   = 1'b0;
            res_err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        alu_a_d    = rf_rd1;
        alu_b_d    = rf_rd2;
        alu_code_d = code_q;
        state_d    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_c;
        res_rd_d    = rd_q;
        // Overflow is only meaningful for arithmetic ops
        res_ovf_d   = alu_ovf && (code_class(code_q) == ALU_CLASS_ARITH);
        res_err_d   = 1'b0;
        state_d     = ST_WB;
      end
      ST_WB: begin
        if (res_ovf) begin
          ovf_sticky_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a small behavioural ALU attached.
module tb_alu_op_issuer;
  import alu_op_issuer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_code;
  logic        alu_ovf;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic        res_ovf, res_err, ovf_sticky, ovf_clr;
  logic        force_ovf;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_op_issuer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_code   (alu_code),
    .alu_c      (alu_c),
    .alu_ovf    (alu_ovf),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .res_ovf    (res_ovf),
    .res_err    (res_err),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  // Behavioural ALU; force_ovf lets the bench raise overflow on any op
  always_comb begin
    alu_c   = 16'h0000;
    alu_ovf = 1'b0;
    case (alu_code[4:3])
      2'b00: begin
        if (alu_code[2:0] == 3'd1) begin
          alu_c   = alu_a - alu_b;
          alu_ovf = (alu_a[15] != alu_b[15]) && (alu_c[15] != alu_a[15]);
        end else begin
          alu_c   = alu_a + alu_b;
          alu_ovf = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
        end
      end
      2'b01: begin
        case (alu_code[2:0])
          3'd0:    alu_c = alu_a & alu_b;
          3'd1:    alu_c = alu_a | alu_b;
          3'd2:    alu_c = alu_a ^ alu_b;
          3'd4:    alu_c = ~alu_a;
          default: alu_c = 16'h0000;
        endcase
      end
      2'b10: begin
        case (alu_code[2:0])
          3'd0:    alu_c = alu_a << alu_b[3:0];
          3'd1:    alu_c = alu_a >> alu_b[3:0];
          3'd2:    alu_c = 16'($signed(alu_a) >>> alu_b[3:0]);
          default: alu_c = alu_a;
        endcase
      end
      default: begin
        case (alu_code[2:0])
          3'd0:    alu_c = {15'd0, alu_a == alu_b};
          3'd1:    alu_c = {15'd0, alu_a != alu_b};
          3'd2:    alu_c = {15'd0, $signed(alu_a) < $signed(alu_b)};
          3'd3:    alu_c = {15'd0, alu_a < alu_b};
          3'd4:    alu_c = {15'd0, $signed(alu_a) >= $signed(alu_b)};
          default: alu_c = {15'd0, alu_a >= alu_b};
        endcase
      end
    endcase
    alu_ovf = alu_ovf | force_ovf;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] code, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {code, rd, rs1, rs2, 2'b00};
  endfunction

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic clr_sticky();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  // Issues one instruction and waits (bounded) for res_valid. Optionally
  // fires a load during the ISSUE cycle or the WB cycle, or ovf_clr in WB.
  task automatic do_op(input logic [15:0] instr, input bit ld_issue, input bit ld_wb,
                       input logic [2:0] la, input logic [15:0] ldd, input bit clr_wb,
                       output int lat, output logic [15:0] d, output logic ovf,
                       output logic err, output logic [2:0] rd);
    @(negedge clk);
    check("in_ready_before_op", 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    if (ld_issue) begin
      ld_valid = 1'b1;
      ld_addr  = la;
      ld_data  = ldd;
    end
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      ld_valid = 1'b0;
      lat++;
    end
    d   = res_data;
    ovf = res_ovf;
    err = res_err;
    rd  = res_rd;
    if (ld_wb) begin
      ld_valid = 1'b1;
      ld_addr  = la;
      ld_data  = ldd;
    end
    ovf_clr = clr_wb;
    @(negedge clk);
    ld_valid = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  // Observes R[idx] by issuing OR rd=idx, rs1=idx, rs2=R0 (R0 stays zero)
  task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
    int lat;
    logic o, e;
    logic [2:0] r;
    do_op(mk(5'b01001, idx, idx, 3'd0), 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, lat, val, o, e, r);
    check("readback_latency", 16'(lat), 16'd3);
  endtask

  typedef struct {
    logic [4:0]  code;
    logic [2:0]  rd, rs1, rs2;
    logic [15:0] a, b;
    bit          fovf;
    logic [15:0] exp_d;
    bit          exp_ovf;
    bit          exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [15:0] d, rb;
    logic        o, e;
    logic [2:0]  r;

    vecs[0]  = '{5'b00000, 3'd3, 3'd1, 3'd2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0};
    vecs[1]  = '{5'b01000, 3'd4, 3'd5, 3'd6, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 1'b0, 1'b0};
    vecs[2]  = '{5'b00001, 3'd5, 3'd1, 3'd2, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[3]  = '{5'b00001, 3'd6, 3'd1, 3'd2, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0};
    vecs[4]  = '{5'b01010, 3'd7, 3'd3, 3'd4, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 1'b0, 1'b0};
    vecs[5]  = '{5'b01011, 3'd4, 3'd1, 3'd2, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{5'b10000, 3'd2, 3'd5, 3'd6, 16'h0001, 16'h0004, 1'b1, 16'h0010, 1'b0, 1'b0};
    vecs[7]  = '{5'b11101, 3'd1, 3'd3, 3'd4, 16'h0010, 16'h0010, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[8]  = '{5'b11110, 3'd3, 3'd1, 3'd2, 16'h0001, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{5'b01100, 3'd6, 3'd5, 3'd2, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 1'b0, 1'b0};
    vecs[10] = '{5'b00111, 3'd7, 3'd1, 3'd2, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b1, 1'b0};
    vecs[11] = '{5'b10100, 3'd5, 3'd1, 3'd2, 16'h0003, 16'h0004, 1'b0, 16'h0000, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; ld_valid = 1'b0; ld_addr = '0;
    ld_data = '0; ovf_clr = 1'b0; force_ovf = 1'b0;
    #12;
    check("rst_alu_a", alu_a, 16'h0);
    check("rst_alu_b", alu_b, 16'h0);
    check("rst_alu_code", 16'(alu_code), 16'h0);
    check("rst_res_valid", 16'(res_valid), 16'h0);
    check("rst_res_data", res_data, 16'h0);
    check("rst_res_flags", 16'({res_ovf, res_err, ovf_sticky}), 16'h0);
    check("rst_res_rd", 16'(res_rd), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 16'(in_ready), 16'd1);

    // Table-driven single ops
    for (int i = 0; i < 12; i++) begin
      clr_sticky();
      load(vecs[i].rd, 16'h1111);
      load(vecs[i].rs1, vecs[i].a);
      load(vecs[i].rs2, vecs[i].b);
      force_ovf = vecs[i].fovf;
      do_op(mk(vecs[i].code, vecs[i].rd, vecs[i].rs1, vecs[i].rs2), 1'b0, 1'b0, 3'd0, 16'h0,
            1'b0, lat, d, o, e, r);
      force_ovf = 1'b0;
      check($sformatf("v%0d_latency", i), 16'(lat), vecs[i].exp_err ? 16'd1 : 16'd3);
      check($sformatf("v%0d_res_err", i), 16'(e), 16'(vecs[i].exp_err));
      check($sformatf("v%0d_res_ovf", i), 16'(o), 16'(vecs[i].exp_ovf));
      check($sformatf("v%0d_res_rd", i), 16'(r), 16'(vecs[i].rd));
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d_alu_code_held", i), 16'(alu_code), 16'(5'b01001));
      end else begin
        check($sformatf("v%0d_res_data", i), d, vecs[i].exp_d);
        check($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
        check($sformatf("v%0d_alu_b", i), alu_b, vecs[i].b);
        check($sformatf("v%0d_alu_code", i), 16'(alu_code), 16'(vecs[i].code));
      end
      read_reg(vecs[i].rd, rb);
      check($sformatf("v%0d_reg_rd", i), rb, vecs[i].exp_err ? 16'h1111 : vecs[i].exp_d);
      check($sformatf("v%0d_ovf_sticky", i), 16'(ovf_sticky), 16'(vecs[i].exp_ovf));
    end

    // Back-to-back with in_valid held; second op depends on first op's rd
    load(3'd1, 16'h0002);
    load(3'd2, 16'h0003);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = mk(5'b00000, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    in_instr = mk(5'b00000, 3'd4, 3'd3, 3'd3);
    check("b2b_ready_issue", 16'(in_ready), 16'd0);
    @(negedge clk);
    check("b2b_ready_capture", 16'(in_ready), 16'd0);
    @(negedge clk);
    check("b2b_ready_wb", 16'(in_ready), 16'd0);
    check("b2b_first_valid", 16'(res_valid), 16'd1);
    check("b2b_first_data", res_data, 16'h0005);
    @(negedge clk);
    check("b2b_ready_idle", 16'(in_ready), 16'd1);
    check("b2b_valid_pulse", 16'(res_valid), 16'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_busy", 16'(in_ready), 16'd0);
    @(negedge clk);
    @(negedge clk);
    check("b2b_second_valid", 16'(res_valid), 16'd1);
    check("b2b_second_data", res_data, 16'h000A);
    check("b2b_second_rd", 16'(res_rd), 16'd4);

    // Load to rd in WB is dropped; load to another index in WB lands
    do_op(mk(5'b00000, 3'd5, 3'd1, 3'd2), 1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0, lat, d, o, e, r);
    read_reg(3'd5, rb);
    check("wb_beats_load", rb, 16'h0005);
    do_op(mk(5'b00000, 3'd6, 3'd1, 3'd2), 1'b0, 1'b1, 3'd7, 16'hCAFE, 1'b0, lat, d, o, e, r);
    read_reg(3'd6, rb);
    check("wb_other_rd", rb, 16'h0005);
    read_reg(3'd7, rb);
    check("load_during_wb_other", rb, 16'hCAFE);

    // Load to rs1 during ISSUE is not forwarded
    do_op(mk(5'b00000, 3'd6, 3'd1, 3'd2), 1'b1, 1'b0, 3'd1, 16'h0100, 1'b0, lat, d, o, e, r);
    check("issue_load_not_fwd", d, 16'h0005);
    read_reg(3'd1, rb);
    check("issue_load_landed", rb, 16'h0100);

    // ovf_clr in the same cycle as an overflow set keeps sticky high
    clr_sticky();
    load(3'd1, 16'h7FFF);
    do_op(mk(5'b00000, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, lat, d, o, e, r);
    check("clr_vs_set_ovf", 16'(o), 16'd1);
    check("clr_vs_set_sticky", 16'(ovf_sticky), 16'd1);

    // Reset asserted during CAPTURE abandons the op
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = mk(5'b00000, 3'd4, 3'd1, 3'd2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", alu_a, 16'h0);
    check("mid_rst_alu_b", alu_b, 16'h0);
    check("mid_rst_alu_code", 16'(alu_code), 16'h0);
    check("mid_rst_res_data", res_data, 16'h0);
    check("mid_rst_flags", 16'({res_valid, res_ovf, res_err, ovf_sticky}), 16'h0);
    check("mid_rst_res_rd", 16'(res_rd), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (res_valid) seen++;
      end
      check("mid_rst_no_completion", 16'(seen), 16'd0);
    end
    check("mid_rst_ready", 16'(in_ready), 16'd1);
    read_reg(3'd4, rb);
    check("mid_rst_no_writeback", rb, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
